// File: rtl/shot_pkg.sv
// shot_pkg: shared sizes and types for the player's shot magazine.
package shot_pkg;
  localparam int SHOT_SLOTS = 8;
  typedef logic [3:0] shot_idx_t;
  typedef logic [7:0] shot_vec_t;
endpackage

// File: rtl/shot_slot_timer.sv
// shot_slot_timer: one shot slot; flies for life_frames frame ticks or until done.
module shot_slot_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             launch,
  input  logic             done,
  input  logic             startOfFrame,
  input  logic [CNT_W-1:0] life_frames,
  output logic             active,
  output logic [CNT_W-1:0] life
);
  logic expire;
  assign expire = startOfFrame && life == CNT_W'(1);
  // done and expiry in the same cycle both land on the single clear branch
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      active <= 1'b0;
      life   <= '0;
    end else if (launch) begin
      active <= 1'b1;
      life   <= life_frames;
    end else if (active && (done || expire)) begin
      active <= 1'b0;
      life   <= '0;
    end else if (active && startOfFrame) begin
      life <= life - CNT_W'(1);
    end
endmodule

// File: rtl/shot_stack.sv
// shot_stack: 8-shot magazine turning fire-key edges into per-slot shot lifetimes.
module shot_stack
  import shot_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int LIFE_FRAMES     = 60,
  parameter int CNT_W           = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      fireKey,
  input  logic      startOfFrame,
  input  shot_vec_t shotDone,
  input  logic      SHP_reload,
  output shot_vec_t shootEnable,
  output shot_idx_t shotsLeft,
  output logic      fireAccepted
);
  logic             fire_d;
  shot_idx_t        ptr;
  logic [CNT_W-1:0] cooldown;
  logic             launch;
  logic [CNT_W-1:0] unused_life [SHOT_SLOTS];
  // ptr[3] set means the magazine is empty; reload in the same cycle drops the edge
  assign launch = fireKey && !fire_d && !ptr[3] && cooldown == '0 &&
                  !shootEnable[ptr[2:0]] && !SHP_reload;
  assign shotsLeft = shot_idx_t'(SHOT_SLOTS) - ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fire_d       <= 1'b0;
      fireAccepted <= 1'b0;
      ptr          <= '0;
      cooldown     <= '0;
    end else begin
      fire_d       <= fireKey;
      fireAccepted <= launch;
      ptr          <= SHP_reload ? '0 : ptr + shot_idx_t'(launch);
      cooldown     <= launch ? CNT_W'(COOLDOWN_FRAMES)
                             : cooldown - CNT_W'(startOfFrame && cooldown != '0);
    end
  for (genvar i = 0; i < SHOT_SLOTS; i++) begin : g_slot
    shot_slot_timer #(.CNT_W(CNT_W)) u_slot (
      .clk          (clk),
      .reset        (reset),
      .launch       (launch && ptr[2:0] == 3'(i)),
      .done         (shotDone[i]),
      .startOfFrame (startOfFrame),
      .life_frames  (CNT_W'(LIFE_FRAMES)),
      .active       (shootEnable[i]),
      .life         (unused_life[i])
    );
  end
endmodule

// File: tb/tb_shot_stack.sv
// tb_shot_stack: directed checks of magazine, cooldown, lifetime, reload and reset.
module tb_shot_stack;
  import shot_pkg::*;
  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      fireKey = 1'b0;
  logic      startOfFrame = 1'b0;
  shot_vec_t shotDone = '0;
  logic      SHP_reload = 1'b0;
  shot_vec_t shootEnable;
  shot_idx_t shotsLeft;
  logic      fireAccepted;
  int        passed = 0;
  int        total = 0;
  int        acc;
  logic [8:0] mask;

  shot_stack #(.COOLDOWN_FRAMES(4), .LIFE_FRAMES(60), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .fireKey      (fireKey),
    .startOfFrame (startOfFrame),
    .shotDone     (shotDone),
    .SHP_reload   (SHP_reload),
    .shootEnable  (shootEnable),
    .shotsLeft    (shotsLeft),
    .fireAccepted (fireAccepted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press();
    fireKey = 1'b1;
    tick();
    fireKey = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  initial begin
    tick();
    check("rst_en", shootEnable, 8'h00);
    check("rst_left", shotsLeft, 4'd8);
    check("rst_acc", fireAccepted, 1'b0);
    reset = 1'b0;
    tick();
    // eight spaced presses fill slots 0..7 in order
    for (int k = 0; k < 8; k++) begin
      press();
      mask = (9'd1 << (k + 1)) - 9'd1;
      check("fill_acc", fireAccepted, 1'b1);
      check("fill_en", shootEnable, mask[7:0]);
      check("fill_left", shotsLeft, 32'(7 - k));
      frames(5);
    end
    press();
    check("ninth_acc", fireAccepted, 1'b0);
    check("ninth_left", shotsLeft, 4'd0);
    check("ninth_en", shootEnable, 8'hFF);
    shotDone = 8'hFF;
    tick();
    shotDone = '0;
    check("done_all", shootEnable, 8'h00);
    SHP_reload = 1'b1;
    tick();
    SHP_reload = 1'b0;
    check("reload_left", shotsLeft, 4'd8);
    // held key fires exactly once
    acc = 0;
    fireKey = 1'b1;
    repeat (100) begin
      tick();
      acc += int'(fireAccepted);
    end
    fireKey = 1'b0;
    check("hold_once", acc, 1);
    check("hold_left", shotsLeft, 4'd7);
    frames(2);
    press();
    check("cool_rej", fireAccepted, 1'b0);
    check("cool_left", shotsLeft, 4'd7);
    frames(2);
    press();
    check("cool_ok", fireAccepted, 1'b1);
    check("cool_en", shootEnable, 8'h03);
    check("cool_left2", shotsLeft, 4'd6);
    // fresh start for lifetime test
    shotDone = 8'hFF;
    SHP_reload = 1'b1;
    tick();
    shotDone = '0;
    SHP_reload = 1'b0;
    frames(4);
    press();
    check("life_launch", shootEnable, 8'h01);
    frames(59);
    check("life_59", shootEnable[0], 1'b1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("life_60", shootEnable[0], 1'b0);
    tick();
    press();
    check("s1_launch", shootEnable, 8'h02);
    frames(3);
    shotDone = 8'h02;
    tick();
    shotDone = '0;
    check("s1_done", shootEnable, 8'h00);
    check("s1_left", shotsLeft, 4'd6);
    // empty the magazine with slot 0 still flying, then reload
    SHP_reload = 1'b1;
    tick();
    SHP_reload = 1'b0;
    frames(1);
    press();
    for (int k = 1; k < 8; k++) begin
      frames(4);
      press();
    end
    check("empty_left", shotsLeft, 4'd0);
    check("empty_en", shootEnable, 8'hFF);
    shotDone = 8'hFE;
    tick();
    shotDone = '0;
    SHP_reload = 1'b1;
    tick();
    SHP_reload = 1'b0;
    check("refill_left", shotsLeft, 4'd8);
    check("refill_en", shootEnable, 8'h01);
    frames(4);
    press();
    check("blocked_acc", fireAccepted, 1'b0);
    check("blocked_left", shotsLeft, 4'd8);
    shotDone = 8'h01;
    tick();
    shotDone = '0;
    press();
    check("unblock_acc", fireAccepted, 1'b1);
    check("unblock_en", shootEnable, 8'h01);
    check("unblock_left", shotsLeft, 4'd7);
    // reload wins over a simultaneous edge
    frames(4);
    fireKey = 1'b1;
    SHP_reload = 1'b1;
    tick();
    fireKey = 1'b0;
    SHP_reload = 1'b0;
    check("race_acc", fireAccepted, 1'b0);
    check("race_left", shotsLeft, 4'd8);
    check("race_en", shootEnable, 8'h01);
    // shotDone together with expiry: slot 0 has 56 frames left here
    frames(55);
    check("coinc_pre", shootEnable[0], 1'b1);
    startOfFrame = 1'b1;
    shotDone = 8'h01;
    tick();
    startOfFrame = 1'b0;
    shotDone = '0;
    check("coinc_clr", shootEnable, 8'h00);
    tick();
    check("coinc_stay", shootEnable, 8'h00);
    press();
    check("coinc_relaunch", shootEnable, 8'h01);
    // five slots flying with cooldown running, then async reset
    for (int k = 1; k < 5; k++) begin
      frames(4);
      press();
    end
    check("five_en", shootEnable, 8'h1F);
    check("five_left", shotsLeft, 4'd3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_en", shootEnable, 8'h00);
    check("arst_left", shotsLeft, 4'd8);
    check("arst_acc", fireAccepted, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("post_acc0", fireAccepted, 1'b0);
    press();
    check("post_acc", fireAccepted, 1'b1);
    check("post_en", shootEnable, 8'h01);
    check("post_left", shotsLeft, 4'd7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
